// File: rtl/pipelined_shift_unit_pkg.sv
// Shared constants for the pipelined shift unit: shift opcode encoding
// used by the decoder, the ALU and every shift level.
package pipelined_shift_unit_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SHOP_SLL = 2'b00;
  localparam shift_op_t SHOP_SRL = 2'b01;
  localparam shift_op_t SHOP_SRA = 2'b10;
  localparam shift_op_t SHOP_ROL = 2'b11;

endpackage

// File: rtl/pipelined_shift_unit_if.sv
// Operand-in / result-out bus of the pipelined shift unit. A transfer happens
// on a rising edge where valid & ready are both 1; valid must not depend on ready.
interface pipelined_shift_unit_if
  import pipelined_shift_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
);

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SHAMT_W-1:0] in_shamt;
  shift_op_t          in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/pipelined_shift_unit_shift_level.sv
// One combinational barrel-shifter level: shifts by the fixed distance DIST
// when en is set, otherwise passes data through.
module shift_level
  import pipelined_shift_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIST   = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic              en,
  input  shift_op_t         op,
  input  logic              sign,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = data;
    if (en) begin
      case (op)
        SHOP_SLL: data_out = {data[DATA_W-1-DIST:0], {DIST{1'b0}}};
        SHOP_SRL: data_out = {{DIST{1'b0}}, data[DATA_W-1:DIST]};
        // sign is the MSB of the original operand, not of this level's input
        SHOP_SRA: data_out = {{DIST{sign}}, data[DATA_W-1:DIST]};
        default:  data_out = {data[DATA_W-1-DIST:0], data[DATA_W-1 -: DIST]};
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with tag pass-through, a global
// stall driven by the output handshake, and a synchronous flush.
module pipelined_shift_unit
  import pipelined_shift_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SHAMT_W   = 5,
  parameter int TAG_W     = 5,
  parameter int PIPELINED = 1
) (
  input logic                  clock,
  input logic                  reset,
  input logic                  flush,
  pipelined_shift_unit_if.slave bus
);

  logic stall;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  genvar k;
  generate
    for (k = 0; k < SHAMT_W; k++) begin : g_level
      // level inputs
      logic               valid;
      logic [DATA_W-1:0]  din;
      logic [SHAMT_W-1:0] shamt;
      shift_op_t          op;
      logic               sign;
      logic [TAG_W-1:0]   tag;
      logic [DATA_W-1:0]  dout;
      // stage outputs; shamt is pre-shifted so the next level always uses its MSB
      logic               s_valid;
      logic [DATA_W-1:0]  s_data;
      logic [SHAMT_W-1:0] s_shamt;
      shift_op_t          s_op;
      logic               s_sign;
      logic [TAG_W-1:0]   s_tag;

      if (k == 0) begin : g_src
        assign valid = bus.in_valid;
        assign din   = bus.in_data;
        assign shamt = bus.in_shamt;
        assign op    = bus.in_op;
        assign sign  = bus.in_data[DATA_W-1];
        assign tag   = bus.in_tag;
      end else begin : g_src
        assign valid = g_level[k-1].s_valid;
        assign din   = g_level[k-1].s_data;
        assign shamt = g_level[k-1].s_shamt;
        assign op    = g_level[k-1].s_op;
        assign sign  = g_level[k-1].s_sign;
        assign tag   = g_level[k-1].s_tag;
      end

      shift_level #(
        .DATA_W (DATA_W),
        .DIST   (1 << (SHAMT_W - 1 - k))
      ) u_level (
        .data     (din),
        .en       (shamt[SHAMT_W-1]),
        .op       (op),
        .sign     (sign),
        .data_out (dout)
      );

      if (PIPELINED != 0 || k == SHAMT_W - 1) begin : g_reg
        // flush is applied after the stall hold so it wins over a stall
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            s_valid <= 1'b0;
            s_data  <= '0;
            s_shamt <= '0;
            s_op    <= SHOP_SLL;
            s_sign  <= 1'b0;
            s_tag   <= '0;
          end else begin
            if (!stall) begin
              s_valid <= valid;
              s_data  <= dout;
              s_shamt <= shamt << 1;
              s_op    <= op;
              s_sign  <= sign;
              s_tag   <= tag;
            end
            if (flush) s_valid <= 1'b0;
          end
        end
      end else begin : g_comb
        assign s_valid = valid;
        assign s_data  = dout;
        assign s_shamt = shamt << 1;
        assign s_op    = op;
        assign s_sign  = sign;
        assign s_tag   = tag;
      end
    end
  endgenerate

  assign bus.out_valid = g_level[SHAMT_W-1].s_valid;
  assign bus.out_data  = g_level[SHAMT_W-1].s_data;
  assign bus.out_tag   = g_level[SHAMT_W-1].s_tag;

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Directed testbench for pipelined_shift_unit: 32-bit pipelined, 32-bit
// single-register and 16-bit pipelined instances.
module tb_pipelined_shift_unit;
  import pipelined_shift_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  pipelined_shift_unit_if #(.DATA_W(32), .SHAMT_W(5), .TAG_W(5)) bp ();
  pipelined_shift_unit_if #(.DATA_W(32), .SHAMT_W(5), .TAG_W(5)) bc ();
  pipelined_shift_unit_if #(.DATA_W(16), .SHAMT_W(4), .TAG_W(5)) b16 ();

  pipelined_shift_unit #(.DATA_W(32), .SHAMT_W(5), .TAG_W(5), .PIPELINED(1)) u_dut_p (
    .clock (clock), .reset (reset), .flush (flush), .bus (bp)
  );
  pipelined_shift_unit #(.DATA_W(32), .SHAMT_W(5), .TAG_W(5), .PIPELINED(0)) u_dut_c (
    .clock (clock), .reset (reset), .flush (flush), .bus (bc)
  );
  pipelined_shift_unit #(.DATA_W(16), .SHAMT_W(4), .TAG_W(5), .PIPELINED(1)) u_dut_16 (
    .clock (clock), .reset (reset), .flush (flush), .bus (b16)
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver tasks: offer one op on an idle unit, wait (bounded) for its result
  task automatic issue_p(input shift_op_t op, input logic [31:0] d, input logic [4:0] sh,
                         input logic [4:0] tg, output logic [31:0] res,
                         output logic [4:0] rtg, output int lat);
    bp.in_valid = 1'b1; bp.in_op = op; bp.in_data = d; bp.in_shamt = sh; bp.in_tag = tg;
    @(posedge clock); #1;
    bp.in_valid = 1'b0;
    lat = 1;
    while (!bp.out_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    res = bp.out_data; rtg = bp.out_tag;
    @(posedge clock); #1;
  endtask

  task automatic issue_c(input shift_op_t op, input logic [31:0] d, input logic [4:0] sh,
                         input logic [4:0] tg, output logic [31:0] res,
                         output logic [4:0] rtg, output int lat);
    bc.in_valid = 1'b1; bc.in_op = op; bc.in_data = d; bc.in_shamt = sh; bc.in_tag = tg;
    @(posedge clock); #1;
    bc.in_valid = 1'b0;
    lat = 1;
    while (!bc.out_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    res = bc.out_data; rtg = bc.out_tag;
    @(posedge clock); #1;
  endtask

  task automatic issue_16(input shift_op_t op, input logic [15:0] d, input logic [3:0] sh,
                          input logic [4:0] tg, output logic [15:0] res,
                          output logic [4:0] rtg, output int lat);
    b16.in_valid = 1'b1; b16.in_op = op; b16.in_data = d; b16.in_shamt = sh; b16.in_tag = tg;
    @(posedge clock); #1;
    b16.in_valid = 1'b0;
    lat = 1;
    while (!b16.out_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    res = b16.out_data; rtg = b16.out_tag;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    checks++; if (bp.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bp.out_valid); end
    checks++; if (bp.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bp.out_data); end
    checks++; if (bp.out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", bp.out_tag); end
    checks++; if (bp.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bp.in_ready); end
    checks++; if (bc.out_valid !== 1'b0 || bc.out_data !== 32'h0) begin errors++; $display("FAIL reset_c got v=%b d=%h want 0 0", bc.out_valid, bc.out_data); end
    checks++; if (b16.out_valid !== 1'b0 || b16.out_data !== 16'h0) begin errors++; $display("FAIL reset_16 got v=%b d=%h want 0 0", b16.out_valid, b16.out_data); end
  endtask

  task automatic test_sll_latency();
    logic [31:0] r; logic [15:0] r16; logic [4:0] t; int lat;
    issue_p(SHOP_SLL, 32'h0000_0001, 5'd31, 5'd7, r, t, lat);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL sll31_p_data got %h want 80000000", r); end
    checks++; if (t !== 5'd7) begin errors++; $display("FAIL sll31_p_tag got %0d want 7", t); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sll31_p_latency got %0d want 5", lat); end
    issue_c(SHOP_SLL, 32'h0000_0001, 5'd31, 5'd7, r, t, lat);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL sll31_c_data got %h want 80000000", r); end
    checks++; if (t !== 5'd7) begin errors++; $display("FAIL sll31_c_tag got %0d want 7", t); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sll31_c_latency got %0d want 1", lat); end
    issue_16(SHOP_SLL, 16'h0001, 4'd15, 5'd7, r16, t, lat);
    checks++; if (r16 !== 16'h8000) begin errors++; $display("FAIL sll15_16_data got %h want 8000", r16); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sll15_16_latency got %0d want 4", lat); end
  endtask

  task automatic test_sra_srl();
    logic [31:0] r; logic [15:0] r16; logic [4:0] t; int lat;
    issue_p(SHOP_SRA, 32'h8000_0000, 5'd4, 5'd1, r, t, lat);
    checks++; if (r !== 32'hF800_0000) begin errors++; $display("FAIL sra_neg_p got %h want f8000000", r); end
    issue_p(SHOP_SRL, 32'h8000_0000, 5'd4, 5'd2, r, t, lat);
    checks++; if (r !== 32'h0800_0000) begin errors++; $display("FAIL srl_p got %h want 08000000", r); end
    issue_p(SHOP_SRA, 32'h7FFF_FFF0, 5'd4, 5'd3, r, t, lat);
    checks++; if (r !== 32'h07FF_FFFF) begin errors++; $display("FAIL sra_pos_p got %h want 07ffffff", r); end
    issue_p(SHOP_SRA, 32'h8000_0000, 5'd31, 5'd4, r, t, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_p got %h want ffffffff", r); end
    issue_c(SHOP_SRA, 32'h8000_0000, 5'd4, 5'd1, r, t, lat);
    checks++; if (r !== 32'hF800_0000) begin errors++; $display("FAIL sra_neg_c got %h want f8000000", r); end
    issue_c(SHOP_SRL, 32'h8000_0000, 5'd4, 5'd2, r, t, lat);
    checks++; if (r !== 32'h0800_0000) begin errors++; $display("FAIL srl_c got %h want 08000000", r); end
    issue_16(SHOP_SRA, 16'h8000, 4'd4, 5'd1, r16, t, lat);
    checks++; if (r16 !== 16'hF800) begin errors++; $display("FAIL sra_neg_16 got %h want f800", r16); end
    issue_16(SHOP_SRL, 16'h8000, 4'd4, 5'd2, r16, t, lat);
    checks++; if (r16 !== 16'h0800) begin errors++; $display("FAIL srl_16 got %h want 0800", r16); end
    issue_16(SHOP_SRA, 16'h7FF0, 4'd4, 5'd3, r16, t, lat);
    checks++; if (r16 !== 16'h07FF) begin errors++; $display("FAIL sra_pos_16 got %h want 07ff", r16); end
  endtask

  task automatic test_rol_zero();
    logic [31:0] r; logic [15:0] r16; logic [4:0] t; int lat;
    issue_p(SHOP_ROL, 32'h8000_0001, 5'd1, 5'd5, r, t, lat);
    checks++; if (r !== 32'h0000_0003) begin errors++; $display("FAIL rol1_p got %h want 00000003", r); end
    issue_p(SHOP_ROL, 32'h1234_5678, 5'd16, 5'd6, r, t, lat);
    checks++; if (r !== 32'h5678_1234) begin errors++; $display("FAIL rol16_p got %h want 56781234", r); end
    issue_c(SHOP_ROL, 32'h1234_5678, 5'd16, 5'd6, r, t, lat);
    checks++; if (r !== 32'h5678_1234) begin errors++; $display("FAIL rol16_c got %h want 56781234", r); end
    for (int o = 0; o < 4; o++) begin
      issue_p(shift_op_t'(o), 32'hDEAD_BEEF, 5'd0, 5'(o), r, t, lat);
      checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL shamt0_p op=%0d got %h want deadbeef", o, r); end
      issue_16(shift_op_t'(o), 16'hBEEF, 4'd0, 5'(o), r16, t, lat);
      checks++; if (r16 !== 16'hBEEF) begin errors++; $display("FAIL shamt0_16 op=%0d got %h want beef", o, r16); end
    end
    issue_16(SHOP_ROL, 16'h8001, 4'd1, 5'd5, r16, t, lat);
    checks++; if (r16 !== 16'h0003) begin errors++; $display("FAIL rol1_16 got %h want 0003", r16); end
    issue_16(SHOP_ROL, 16'h1234, 4'd8, 5'd6, r16, t, lat);
    checks++; if (r16 !== 16'h3412) begin errors++; $display("FAIL rol8_16 got %h want 3412", r16); end
  endtask

  // 8 ops offered back to back; consumer stalls in cycles 6..9
  task automatic test_back_to_back();
    shift_op_t   vop  [8];
    logic [31:0] vdat [8];
    logic [4:0]  vsh  [8];
    logic [31:0] vexp [8];
    logic [36:0] exp_q[$];
    logic [36:0] held, got, want;
    logic        was_stall, exp_ready;
    int          idx, n_out;
    vop  = '{SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_ROL, SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_ROL};
    vdat = '{32'h0000_00FF, 32'hF000_0000, 32'h8000_0000, 32'hF000_0000,
             32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    vsh  = '{5'd4, 5'd28, 5'd31, 5'd4, 5'd8, 5'd8, 5'd8, 5'd8};
    vexp = '{32'h0000_0FF0, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_000F,
             32'h3456_7800, 32'h0012_3456, 32'h0012_3456, 32'h3456_7812};
    idx = 0; n_out = 0; was_stall = 1'b0; held = '0;
    for (int c = 1; c <= 30 && n_out < 8; c++) begin
      bp.out_ready = !(c >= 6 && c <= 9);
      bp.in_valid  = (idx < 8);
      if (idx < 8) begin
        bp.in_op = vop[idx]; bp.in_data = vdat[idx]; bp.in_shamt = vsh[idx]; bp.in_tag = 5'(idx + 1);
      end
      @(negedge clock);
      exp_ready = !(c >= 6 && c <= 9);
      checks++; if (bp.in_ready !== exp_ready) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, bp.in_ready, exp_ready); end
      if (was_stall) begin
        checks++; if ({bp.out_tag, bp.out_data} !== held) begin errors++; $display("FAIL b2b_hold cycle %0d got %h want %h", c, {bp.out_tag, bp.out_data}, held); end
      end
      was_stall = bp.out_valid & ~bp.out_ready;
      held = {bp.out_tag, bp.out_data};
      if (bp.in_valid && bp.in_ready) begin
        exp_q.push_back({5'(idx + 1), vexp[idx]});
        idx++;
      end
      if (bp.out_valid && bp.out_ready) begin
        got = {bp.out_tag, bp.out_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra cycle %0d got %h want none", c, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin errors++; $display("FAIL b2b_result cycle %0d got %h want %h", c, got, want); end
        end
        n_out++;
      end
      @(posedge clock); #1;
    end
    bp.in_valid = 1'b0; bp.out_ready = 1'b1;
    checks++; if (n_out !== 8 || idx !== 8) begin errors++; $display("FAIL b2b_count got out=%0d in=%0d want 8 8", n_out, idx); end
  endtask

  task automatic test_flush();
    logic [31:0] r; logic [4:0] t; int lat, seen;
    for (int i = 0; i < 3; i++) begin
      bp.in_valid = 1'b1; bp.in_op = SHOP_SLL; bp.in_data = 32'h1; bp.in_shamt = 5'(i); bp.in_tag = 5'(10 + i);
      @(posedge clock); #1;
    end
    flush = 1'b1; bp.in_op = SHOP_SLL; bp.in_data = 32'hFF; bp.in_shamt = 5'd0; bp.in_tag = 5'd20;
    @(posedge clock); #1;
    flush = 1'b0; bp.in_valid = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clock); if (bp.out_valid) seen++;
      @(posedge clock); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_output got %0d results want 0", seen); end
    issue_p(SHOP_SRL, 32'h0000_F000, 5'd12, 5'd21, r, t, lat);
    checks++; if (r !== 32'h0000_000F) begin errors++; $display("FAIL post_flush_data got %h want 0000000f", r); end
    checks++; if (t !== 5'd21) begin errors++; $display("FAIL post_flush_tag got %0d want 21", t); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL post_flush_latency got %0d want 5", lat); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bp.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp.in_valid = 1'b1; bp.in_op = SHOP_SLL; bp.in_data = 32'(i + 1); bp.in_shamt = 5'd0; bp.in_tag = 5'(i + 1);
      @(posedge clock); #1;
    end
    bp.in_valid = 1'b0;
    checks++; if (bp.out_valid !== 1'b1) begin errors++; $display("FAIL pipe_full_before_reset got %b want 1", bp.out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bp.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b want 0", bp.out_valid); end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (bp.out_data !== 32'h0 || bp.out_tag !== 5'h0) begin errors++; $display("FAIL after_reset_outputs got %h/%h want 0/0", bp.out_data, bp.out_tag); end
    checks++; if (bp.in_ready !== 1'b1) begin errors++; $display("FAIL after_reset_in_ready got %b want 1", bp.in_ready); end
    bp.out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clock); if (bp.out_valid) seen++;
      @(posedge clock); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_drops_inflight got %0d results want 0", seen); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bp.in_valid = 1'b0;  bp.in_data = '0;  bp.in_shamt = '0;  bp.in_op = SHOP_SLL;  bp.in_tag = '0;  bp.out_ready = 1'b1;
    bc.in_valid = 1'b0;  bc.in_data = '0;  bc.in_shamt = '0;  bc.in_op = SHOP_SLL;  bc.in_tag = '0;  bc.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_shamt = '0; b16.in_op = SHOP_SLL; b16.in_tag = '0; b16.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    test_reset();
    @(posedge clock); #1;
    test_sll_latency();
    test_sra_srl();
    test_rol_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
